// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl_if
// Description : Pipeline request/response handshake and byte-addressed data
//               memory port of the load/store unit, bundled in one interface.
//               slave  = the LSU controller's view.
//               master = the environment's view (pipeline + memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if;
  // Pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Pipeline response
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  // Memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [31:0] mem_rdata_raw;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_rdata_raw,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_addr, mem_wdata, mem_byte_en, mem_read_req, mem_write_req
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_rdata_raw,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_addr, mem_wdata, mem_byte_en, mem_read_req, mem_write_req
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store initiator for the data memory. Accepts one request
//               at a time, issues one or two word-aligned beats (two when the
//               access crosses a word boundary), lane-aligns store data,
//               extends load data and returns a single response.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int unsigned MEM_SIZE = 8192
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q;

  // Latched request fields
  logic        we_q;
  logic        sext_q;
  logic        split_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_hi_q;
  logic [3:0]  en_hi_q;
  logic [31:0] beat0_q;

  // Registered outputs
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_byte_en_q;
  logic        mem_read_req_q;
  logic        mem_write_req_q;

  // Request decode: only consumed when a request is latched in IDLE
  logic [2:0]  req_size;
  logic [31:0] req_wmask;
  logic        req_f3_bad;
  logic [32:0] req_end;
  logic        req_range_bad;
  logic        req_illegal;
  logic        req_split;
  logic [63:0] req_sh;
  logic [7:0]  req_en_base;
  logic [7:0]  req_en;

  // Decode size, legality, split, lane-shifted store data and byte enables
  always_comb begin
    req_size  = 3'd0;
    req_wmask = 32'h0000_0000;
    case (bus.req_funct3[1:0])
      2'b00:   begin req_size = 3'd1; req_wmask = 32'h0000_00FF; end
      2'b01:   begin req_size = 3'd2; req_wmask = 32'h0000_FFFF; end
      2'b10:   begin req_size = 3'd4; req_wmask = 32'hFFFF_FFFF; end
      default: begin req_size = 3'd0; req_wmask = 32'h0000_0000; end
    endcase
    if (bus.req_we) begin
      req_f3_bad = (bus.req_funct3 >= 3'd3);
    end else begin
      req_f3_bad = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                   (bus.req_funct3 == 3'd7);
    end
    // 33-bit sum so that addresses near 2^32 cannot wrap back into range
    req_end       = {1'b0, bus.req_addr} + {30'd0, req_size};
    req_range_bad = (req_end > 33'(MEM_SIZE));
    req_illegal   = req_f3_bad || req_range_bad;
    req_split     = (({1'b0, bus.req_addr[1:0]} + req_size) > 3'd4);
    req_sh        = {32'd0, bus.req_wdata & req_wmask} << {bus.req_addr[1:0], 3'b000};
    req_en_base   = (8'd1 << req_size) - 8'd1;
    req_en        = req_en_base << bus.req_addr[1:0];
  end

  // Zero the lanes the current beat did not enable; those bytes are garbage
  function automatic logic [31:0] lane_mask(input logic [31:0] data, input logic [3:0] en);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = en[i] ? data[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  logic [31:0] beat_lo;
  logic [31:0] beat_hi;
  logic [31:0] aligned;
  logic [31:0] load_d;

  // Assemble the load result from the beat(s), shift out the offset, extend
  always_comb begin
    beat_lo = (state_q == ACC0) ? lane_mask(bus.mem_rdata_raw, mem_byte_en_q) : beat0_q;
    beat_hi = (state_q == ACC1) ? lane_mask(bus.mem_rdata_raw, mem_byte_en_q) : 32'd0;
    aligned = 32'({beat_hi, beat_lo} >> {off_q, 3'b000});
    load_d  = aligned;
    case (size_q)
      3'd1:    load_d = {{24{sext_q & aligned[7]}},  aligned[7:0]};
      3'd2:    load_d = {{16{sext_q & aligned[15]}}, aligned[15:0]};
      default: load_d = aligned;
    endcase
    if (we_q) begin
      load_d = 32'd0;
    end
  end

  // Control FSM with registered outputs and request latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      sext_q          <= 1'b0;
      split_q         <= 1'b0;
      off_q           <= 2'd0;
      size_q          <= 3'd0;
      wdata_hi_q      <= 32'd0;
      en_hi_q         <= 4'd0;
      beat0_q         <= 32'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_fault_q    <= 1'b0;
      resp_rdata_q    <= 32'd0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      mem_byte_en_q   <= 4'd0;
      mem_read_req_q  <= 1'b0;
      mem_write_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            sext_q      <= ~bus.req_funct3[2];
            split_q     <= req_split;
            off_q       <= bus.req_addr[1:0];
            size_q      <= req_size;
            wdata_hi_q  <= req_sh[63:32];
            en_hi_q     <= req_en[7:4];
            req_ready_q <= 1'b0;
            if (req_illegal) begin
              // No memory beat for an illegal request: straight to response
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q         <= ACC0;
              mem_addr_q      <= {bus.req_addr[31:2], 2'b00};
              mem_byte_en_q   <= req_en[3:0];
              mem_wdata_q     <= req_sh[31:0];
              mem_read_req_q  <= ~bus.req_we;
              mem_write_req_q <= bus.req_we;
            end
          end
        end
        ACC0: begin
          beat0_q <= lane_mask(bus.mem_rdata_raw, mem_byte_en_q);
          if (split_q) begin
            state_q       <= ACC1;
            mem_addr_q    <= mem_addr_q + 32'd4;
            mem_byte_en_q <= en_hi_q;
            mem_wdata_q   <= wdata_hi_q;
          end else begin
            state_q         <= RESP;
            mem_addr_q      <= 32'd0;
            mem_byte_en_q   <= 4'd0;
            mem_wdata_q     <= 32'd0;
            mem_read_req_q  <= 1'b0;
            mem_write_req_q <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_fault_q    <= 1'b0;
            resp_rdata_q    <= load_d;
          end
        end
        ACC1: begin
          state_q         <= RESP;
          mem_addr_q      <= 32'd0;
          mem_byte_en_q   <= 4'd0;
          mem_wdata_q     <= 32'd0;
          mem_read_req_q  <= 1'b0;
          mem_write_req_q <= 1'b0;
          resp_valid_q    <= 1'b1;
          resp_fault_q    <= 1'b0;
          resp_rdata_q    <= load_d;
        end
        RESP: begin
          // Response held until consumed; no new accept in this cycle
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_fault    = resp_fault_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_byte_en   = mem_byte_en_q;
  assign bus.mem_read_req  = mem_read_req_q;
  assign bus.mem_write_req = mem_write_req_q;

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Initiator side of the data-memory interface: accepts one load/store at a time from the pipeline MEM stage and drives the byte-addressed memory port (mem_addr, mem_wdata, mem_byte_en, mem_read_req, mem_write_req, mem_rdata_raw).
- Generates byte enables, lane-aligns store data, splits word-crossing accesses into two aligned beats, and sign/zero-extends load data.
- Returns a single response to the pipeline through a valid/ready handshake.

Parameters:
MEM_SIZE, 8192, memory size in bytes. Any access whose bytes extend past it faults.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  block idle, request accepted this cycle if req_valid
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 funct3: LB000 LH001 LW010 LBU100 LHU101; SB000 SH001 SW010
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response valid
resp_ready  in  1  pipeline consumes response
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  out-of-range address or illegal funct3
mem_addr  out  32  word-aligned beat address
mem_wdata  out  32  lane-aligned store data; lane i = byte at mem_addr+i
mem_byte_en  out  4  lane enables
mem_read_req  out  1  read beat
mem_write_req  out  1  write beat, committed by memory at the next rising edge
mem_rdata_raw  in  32  combinational read data, valid in the same cycle as mem_read_req; disabled lanes are garbage

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1. resp_valid, resp_fault, mem_read_req and mem_write_req are 0. resp_rdata, mem_addr, mem_wdata and mem_byte_en are 0.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr, wdata.
  - Go to ACC0, or to RESP with fault if the request is illegal.
- Access size: 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
- Illegal requests:
  - funct3 011, 110 or 111 on a load.
  - funct3 >= 011 on a store.
  - addr + size > MEM_SIZE, evaluated in 33-bit arithmetic.
  - An illegal request issues no memory beat.
- Offset and split: off = addr[1:0]. The access is split when off + size > 4.
- Store data: sh = {32'b0, wdata masked to size} << 8*off, a 64-bit value.
- Byte enables: en = ((1<<size)-1) << off, an 8-bit value.
- ACC0 (one cycle):
  - mem_addr = addr & ~3, mem_byte_en = en[3:0], mem_wdata = sh[31:0].
  - Read or write request asserted per we.
  - Load data lanes are captured at the clock edge.
  - Next state is ACC1 if split, else RESP.
- ACC1 (one cycle):
  - mem_addr = (addr & ~3) + 4, mem_byte_en = en[7:4], mem_wdata = sh[63:32].
  - Next state is RESP.
- Load assembly:
  - raw64 = {beat1, beat0} >> 8*off; beat1 = 0 if there is no split.
  - Keep the low size bytes.
  - LB and LH sign-extend. LBU, LHU and LW zero-extend.
  - Disabled lanes never reach resp_rdata.
- RESP:
  - resp_valid=1, with resp_rdata and resp_fault held stable until resp_ready.
  - On resp_ready, go to IDLE.
  - req_ready=0, so there is no same-cycle accept-on-complete.
- Latency, request accept to resp_valid: aligned access 2 cycles, split access 3 cycles, fault 1 cycle.
- mem_* outputs are decoded only from registered state and latched request fields; there is no combinational path from req_* to mem_*.
- Outside ACC0/ACC1: mem_read_req = mem_write_req = 0, and mem_addr, mem_wdata, mem_byte_en = 0.
- Reset mid-operation: all state clears immediately. A split store interrupted after ACC0 leaves beat 0 committed; this is accepted and is not rolled back.
- req_* inputs are ignored outside IDLE. resp_ready is ignored outside RESP.

Test Plan:
- LW at addr 0x100, memory holding 0xDEADBEEF -> mem_addr 0x100, byte_en 1111, one beat; resp_rdata 0xDEADBEEF, fault 0, resp_valid 2 cycles after accept.
- SB addr 0x203 wdata 0x000000A5, then LB and LBU at 0x203 -> write beat byte_en 1000, mem_wdata[31:24] = 0xA5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- SW addr 0x102 wdata 0x11223344 (split) -> beat0 addr 0x100 en 1100 wdata 0x33440000, beat1 addr 0x104 en 0011 wdata 0x00001122; LW 0x102 returns 0x11223344 after 3 cycles.
- LH addr 0x1FFF with MEM_SIZE 8192 -> no mem beat, resp_fault 1, rdata 0; load funct3 011 -> fault.
- Hold resp_ready=0 for 5 cycles after an LHU of 0x8001 -> resp_valid and rdata 0x00008001 stable, req_ready=0; release -> IDLE next cycle.
- Assert rst_n=0 during ACC1 of a split store -> all outputs 0 asynchronously, req_ready=1 after release, the next request executes normally.
